// File: rtl/pipe_pkg.sv
// Shared types and stage payload widths for the MIPS pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int IF_ID_W   = 64;   // {pc, instruction}
    localparam int ID_EX_W   = 147;  // pc, rs/rt values, sign-extended imm, rs/rt/rd, controls
    localparam int EX_MEM_W  = 107;  // alu result, store data, dest reg, branch target, controls
    localparam int MEM_WB_W  = 71;   // load data, alu result, dest reg, controls

endpackage

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register with valid/ready handshake, hazard hold and flush.
// SKID_EN selects a 2-entry skid buffer (registered in_ready) or a single register.
module pipe_elastic_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W         = IF_ID_W,
    parameter int SKID_EN        = 1,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_state_t       r_state;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] r_skid;
            logic              w_in_fire;
            logic              w_out_fire;

            // in_ready comes only from r_state so no ready path crosses the stage.
            assign w_in_fire  = in_valid && (r_state != ST_TWO);
            assign w_out_fire = (r_state != ST_EMPTY) && out_ready && !hold;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end else if (flush) begin
                    r_state <= ST_EMPTY;
                    if (CLEAR_ON_FLUSH != 0) begin
                        r_main <= '0;
                        r_skid <= '0;
                    end
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                r_state <= ST_ONE;
                                r_main  <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                r_main <= in_data;
                            end else if (w_in_fire) begin
                                r_state <= ST_TWO;
                                r_skid  <= in_data;
                            end else if (w_out_fire) begin
                                r_state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (w_out_fire) begin
                                r_state <= ST_ONE;
                                r_main  <= r_skid;
                            end
                        end
                        default: r_state <= ST_EMPTY;
                    endcase
                end
            end

            assign in_ready  = (r_state != ST_TWO);
            assign out_valid = (r_state != ST_EMPTY);
            assign out_data  = r_main;
            assign occupancy = (r_state == ST_TWO) ? 2'd2 :
                               (r_state == ST_ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic              r_valid;
            logic [DATA_W-1:0] r_main;
            logic              w_in_fire;
            logic              w_out_fire;

            assign w_out_fire = r_valid && out_ready && !hold;
            assign w_in_fire  = in_valid && in_ready;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_valid <= 1'b0;
                    r_main  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    if (CLEAR_ON_FLUSH != 0) begin
                        r_main <= '0;
                    end
                end else if (w_in_fire) begin
                    r_valid <= 1'b1;
                    r_main  <= in_data;
                end else if (w_out_fire) begin
                    r_valid <= 1'b0;
                end
            end

            // Combinational ready lets a drain and a refill share one edge.
            assign in_ready  = !r_valid || w_out_fire;
            assign out_valid = r_valid;
            assign out_data  = r_main;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: three variants (skid+clear, skid+keep, single+clear)
// share one stimulus stream and are compared against a queue-level reference model.
module tb_pipe_elastic_stage;
    import pipe_pkg::*;

    localparam int W = IF_ID_W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         hold = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic [2:0]   d_ready;
    logic [2:0]   d_valid;
    logic [W-1:0] d_data [3];
    logic [1:0]   d_occ [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_elastic_stage #(.DATA_W(W), .SKID_EN(1), .CLEAR_ON_FLUSH(1)) u_skid_clr (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(d_ready[0]), .in_data(in_data),
        .out_valid(d_valid[0]), .out_ready(out_ready), .out_data(d_data[0]),
        .occupancy(d_occ[0]));

    pipe_elastic_stage #(.DATA_W(W), .SKID_EN(1), .CLEAR_ON_FLUSH(0)) u_skid_keep (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(d_ready[1]), .in_data(in_data),
        .out_valid(d_valid[1]), .out_ready(out_ready), .out_data(d_data[1]),
        .occupancy(d_occ[1]));

    pipe_elastic_stage #(.DATA_W(W), .SKID_EN(0), .CLEAR_ON_FLUSH(1)) u_single_clr (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(d_ready[2]), .in_data(in_data),
        .out_valid(d_valid[2]), .out_ready(out_ready), .out_data(d_data[2]),
        .occupancy(d_occ[2]));

    // Reference model: a FIFO of up to cap items plus the last value shown on out_data.
    typedef struct packed {
        logic [1:0]   cnt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] shown;
    } mst_t;

    mst_t       m_st [3];
    logic [2:0] e_ready;
    logic [2:0] e_valid;

    function automatic mst_t model_step(mst_t s, bit skid, bit clr);
        mst_t n = s;
        bit   ofire;
        bit   ifire;
        ofire = (s.cnt != 0) && out_ready && !hold;
        ifire = in_valid && (skid ? (s.cnt != 2) : (s.cnt == 0 || ofire));
        if (flush) begin
            n.cnt = 2'd0;
            if (clr) n.shown = '0;
            return n;
        end
        if (ofire) begin
            n.a   = n.b;
            n.cnt = n.cnt - 2'd1;
        end
        if (ifire) begin
            if (n.cnt == 0) n.a = in_data;
            else            n.b = in_data;
            n.cnt = n.cnt + 2'd1;
        end
        if (n.cnt != 0) n.shown = n.a;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int v = 0; v < 3; v++) begin
            if (!reset) m_st[v] <= '0;
            else        m_st[v] <= model_step(m_st[v], (v != 2), (v != 1));
        end
    end

    always_comb begin
        e_ready = '0;
        e_valid = '0;
        for (int v = 0; v < 3; v++) begin
            e_valid[v] = (m_st[v].cnt != 0);
            e_ready[v] = (v != 2) ? (m_st[v].cnt != 2)
                                  : (m_st[v].cnt == 0 || (out_ready && !hold));
        end
    end

    task automatic set_in(input logic v, input logic [W-1:0] d, input logic ordy,
                          input logic hld, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
    endtask

    task automatic clear_all();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        for (int v = 0; v < 3; v++) begin
            total++;
            if (d_valid[v] !== 1'b0 || d_ready[v] !== 1'b1 || d_occ[v] !== 2'd0 || d_data[v] !== 64'd0) begin
                bad++;
                $display("FAIL reset_hold dut=%0d valid=%b ready=%b occ=%0d data=%h (want 0 1 0 0)",
                         v, d_valid[v], d_ready[v], d_occ[v], d_data[v]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 3; v++) begin
            total++;
            if (d_valid[v] !== 1'b0 || d_ready[v] !== 1'b1 || d_occ[v] !== 2'd0 || d_data[v] !== 64'd0) begin
                bad++;
                $display("FAIL reset_release dut=%0d valid=%b ready=%b occ=%0d data=%h (want 0 1 0 0)",
                         v, d_valid[v], d_ready[v], d_occ[v], d_data[v]);
            end
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 64'h0000_0004_2002_0005;
        b = 64'h0000_0008_2003_0007;
        set_in(1'b1, a, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (d_ready[0] !== 1'b1 || d_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL stream_first ready=%b valid=%b (want 1 0)", d_ready[0], d_valid[0]);
        end
        @(negedge clk);
        in_data = b;
        total++;
        if (d_valid[0] !== 1'b1 || d_data[0] !== a || d_occ[0] !== 2'd1 || d_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL stream_a valid=%b data=%h occ=%0d ready=%b (want 1 %h 1 1)",
                     d_valid[0], d_data[0], d_occ[0], d_ready[0], a);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (d_valid[0] !== 1'b1 || d_data[0] !== b || d_occ[0] !== 2'd1 || d_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL stream_b valid=%b data=%h occ=%0d ready=%b (want 1 %h 1 1)",
                     d_valid[0], d_data[0], d_occ[0], d_ready[0], b);
        end
        @(negedge clk);
        total++;
        if (d_valid[0] !== 1'b0 || d_data[0] !== b || d_occ[0] !== 2'd0) begin
            bad++;
            $display("FAIL stream_idle valid=%b data=%h occ=%0d (want 0 %h 0)",
                     d_valid[0], d_data[0], d_occ[0], b);
        end
    endtask

    task automatic test_hold();
        clear_all();
        set_in(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (d_valid[0] !== 1'b1 || d_data[0] !== 64'h11 || d_occ[0] !== 2'd1) begin
            bad++;
            $display("FAIL hold_one valid=%b data=%h occ=%0d (want 1 11 1)", d_valid[0], d_data[0], d_occ[0]);
        end
        set_in(1'b1, 64'h22, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if (d_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL hold_ready_one ready=%b (want 1)", d_ready[0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (d_occ[0] !== 2'd2 || d_ready[0] !== 1'b0 || d_valid[0] !== 1'b1 || d_data[0] !== 64'h11) begin
                bad++;
                $display("FAIL hold_two k=%0d occ=%0d ready=%b valid=%b data=%h (want 2 0 1 11)",
                         k, d_occ[0], d_ready[0], d_valid[0], d_data[0]);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        total++;
        if (d_data[0] !== 64'h22 || d_occ[0] !== 2'd1 || d_ready[0] !== 1'b1 || d_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL hold_a_out data=%h occ=%0d ready=%b valid=%b (want 22 1 1 1)",
                     d_data[0], d_occ[0], d_ready[0], d_valid[0]);
        end
        @(negedge clk);
        total++;
        if (d_valid[0] !== 1'b0 || d_occ[0] !== 2'd0) begin
            bad++;
            $display("FAIL hold_b_out valid=%b occ=%0d (want 0 0)", d_valid[0], d_occ[0]);
        end
    endtask

    task automatic test_flush();
        clear_all();
        set_in(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_data = 64'h66;
        @(negedge clk);
        total++;
        if (d_occ[0] !== 2'd2) begin
            bad++;
            $display("FAIL flush_pre occ=%0d (want 2)", d_occ[0]);
        end
        set_in(1'b1, 64'h33, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (d_valid[0] !== 1'b0 || d_occ[0] !== 2'd0 || d_data[0] !== 64'd0 || d_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL flush_post valid=%b occ=%0d data=%h ready=%b (want 0 0 0 1)",
                     d_valid[0], d_occ[0], d_data[0], d_ready[0]);
        end
        total++;
        if (d_valid[1] !== 1'b0 || d_data[1] !== 64'h55) begin
            bad++;
            $display("FAIL flush_keep_skid valid=%b data=%h (want 0 55)", d_valid[1], d_data[1]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (d_valid[0] !== 1'b0) begin
                bad++;
                $display("FAIL flush_no_c k=%0d valid=%b data=%h (want valid 0)", k, d_valid[0], d_data[0]);
            end
        end
    endtask

    task automatic test_flush_noclear();
        clear_all();
        set_in(1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (d_valid[1] !== 1'b1 || d_data[1] !== 64'h44) begin
            bad++;
            $display("FAIL noclear_load valid=%b data=%h (want 1 44)", d_valid[1], d_data[1]);
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (d_valid[1] !== 1'b0 || d_data[1] !== 64'h44 || d_occ[1] !== 2'd0) begin
            bad++;
            $display("FAIL noclear_flush valid=%b data=%h occ=%0d (want 0 44 0)", d_valid[1], d_data[1], d_occ[1]);
        end
    endtask

    task automatic test_noskid();
        clear_all();
        set_in(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_data = 64'h88;
        #1;
        total++;
        if (d_valid[2] !== 1'b1 || d_data[2] !== 64'h77 || d_ready[2] !== 1'b0) begin
            bad++;
            $display("FAIL noskid_blocked valid=%b data=%h ready=%b (want 1 77 0)", d_valid[2], d_data[2], d_ready[2]);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (d_ready[2] !== 1'b1) begin
            bad++;
            $display("FAIL noskid_comb_ready ready=%b (want 1)", d_ready[2]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (d_valid[2] !== 1'b1 || d_data[2] !== 64'h88 || d_occ[2] !== 2'd1) begin
            bad++;
            $display("FAIL noskid_no_bubble valid=%b data=%h occ=%0d (want 1 88 1)", d_valid[2], d_data[2], d_occ[2]);
        end
        @(negedge clk);
        total++;
        if (d_valid[2] !== 1'b0 || d_occ[2] !== 2'd0) begin
            bad++;
            $display("FAIL noskid_drain valid=%b occ=%0d (want 0 0)", d_valid[2], d_occ[2]);
        end
    endtask

    task automatic test_async_reset();
        clear_all();
        set_in(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_data = 64'haa;
        @(negedge clk);
        total++;
        if (d_occ[0] !== 2'd2) begin
            bad++;
            $display("FAIL areset_pre occ=%0d (want 2)", d_occ[0]);
        end
        #3;
        reset = 1'b0;
        #1;
        for (int v = 0; v < 3; v++) begin
            total++;
            if (d_valid[v] !== 1'b0 || d_ready[v] !== 1'b1 || d_occ[v] !== 2'd0 || d_data[v] !== 64'd0) begin
                bad++;
                $display("FAIL areset dut=%0d valid=%b ready=%b occ=%0d data=%h (want 0 1 0 0)",
                         v, d_valid[v], d_ready[v], d_occ[v], d_data[v]);
            end
        end
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 10) < 7,
                   ($urandom % 100) < 15, ($urandom % 100) < 5);
            #1;
            for (int v = 0; v < 3; v++) begin
                total++;
                if (d_valid[v] !== e_valid[v] || d_ready[v] !== e_ready[v] ||
                    d_occ[v] !== m_st[v].cnt || d_data[v] !== m_st[v].shown) begin
                    bad++;
                    $display("FAIL random cyc=%0d dut=%0d valid=%b/%b ready=%b/%b occ=%0d/%0d data=%h/%h (got/want)",
                             i, v, d_valid[v], e_valid[v], d_ready[v], e_ready[v],
                             d_occ[v], m_st[v].cnt, d_data[v], m_st[v].shown);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_flush();
        test_flush_noclear();
        test_noskid();
        test_async_reset();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
